// File: rtl/axi_rd_mem_slave_if.sv
// AXI read-channel bundle plus the SRAM read port of the memory slave.
// Pure wiring, no latency.
// The master drives AR/RREADY and mem_rdata; the slave drives the rest.
interface axi_rd_mem_slave_if;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic [7:0]  ARLEN;
  logic        RVALID;
  logic        RREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata;
  // Protection bits of the request in flight, kept for observability.
  logic [2:0]  ARPROT_q;

  modport slave (
    input  ARVALID, ARADDR, ARPROT, ARLEN, RREADY, mem_rdata,
    output ARREADY, RVALID, RDATA, RRESP, RLAST, mem_en, mem_addr, ARPROT_q
  );

  modport master (
    output ARVALID, ARADDR, ARPROT, ARLEN, RREADY, mem_rdata,
    input  ARREADY, RVALID, RDATA, RRESP, RLAST, mem_en, mem_addr, ARPROT_q
  );
endinterface

// File: rtl/axi_rd_mem_slave.sv
// AXI read slave in front of a synchronous-read SRAM, one burst at a time, per-beat range/alignment check.
// Latency: AR handshake to first RVALID is LAT+2 edges; each further beat costs at least LAT+3 cycles.
// Backpressure: a beat holds RVALID/RDATA/RRESP/RLAST until RREADY; ARREADY only in IDLE.
module axi_rd_mem_slave #(
  parameter int unsigned LAT  = 2,
  parameter logic [31:0] BASE = 32'h8000_0000,
  parameter logic [31:0] SIZE = 32'h0800_0000
) (
  input logic              ACLK,
  input logic              ARESETn,
  axi_rd_mem_slave_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int          CW   = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam bit          LAT0 = (LAT == 0);
  localparam logic [32:0] LO   = {1'b0, BASE};
  localparam logic [32:0] HI   = {1'b0, BASE} + {1'b0, SIZE};

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [7:0]    r_len;
  logic [7:0]    r_beat;
  logic [2:0]    r_prot;
  logic          r_rvalid;
  logic [63:0]   r_rdata;
  logic [1:0]    r_rresp;
  logic          r_rlast;

  logic          w_last;
  logic          w_do_check;
  logic [31:0]   w_chk_addr;
  logic [7:0]    w_chk_beat;
  logic [7:0]    w_chk_len;
  logic          w_misal;
  logic          w_oor;
  logic          w_chk_err;
  logic [1:0]    w_chk_resp;

  assign w_last = (r_beat == r_len);

  // Beat-check runs on the edge a beat starts: after the wait count, or
  // straight from AR accept / previous beat's handshake when LAT is zero.
  assign w_do_check = ((r_state == S_IDLE) && bus.ARVALID && LAT0) ||
                      ((r_state == S_WAIT) && (r_cnt == CW'(1))) ||
                      ((r_state == S_RESP) && bus.RREADY && !w_last && LAT0);

  // Select the address/beat the starting beat will use.
  always_comb begin
    w_chk_addr = r_addr;
    w_chk_beat = r_beat;
    w_chk_len  = r_len;
    if (r_state == S_IDLE) begin
      w_chk_addr = bus.ARADDR;
      w_chk_beat = 8'd0;
      w_chk_len  = bus.ARLEN;
    end else if (r_state == S_RESP) begin
      w_chk_addr = r_addr + 32'd8;
      w_chk_beat = r_beat + 8'd1;
    end
  end

  assign w_misal    = |w_chk_addr[2:0];
  assign w_oor      = ({1'b0, w_chk_addr} < LO) || ({1'b0, w_chk_addr} >= HI);
  assign w_chk_err  = w_misal || w_oor;
  assign w_chk_resp = w_misal ? 2'b10 : 2'b11;

  // Protection bits are captured with each accepted request.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_prot <= 3'd0;
    end else if ((r_state == S_IDLE) && bus.ARVALID) begin
      r_prot <= bus.ARPROT;
    end
  end

  // Burst sequencer: wait states, SRAM access, capture and response hold.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= 32'd0;
      r_len    <= 8'd0;
      r_beat   <= 8'd0;
      r_rvalid <= 1'b0;
      r_rdata  <= 64'd0;
      r_rresp  <= 2'b00;
      r_rlast  <= 1'b0;
    end else if (w_do_check) begin
      r_addr <= w_chk_addr;
      r_beat <= w_chk_beat;
      r_len  <= w_chk_len;
      if (w_chk_err) begin
        // Error beats skip the SRAM and go straight to the response.
        r_state  <= S_RESP;
        r_rvalid <= 1'b1;
        r_rdata  <= 64'd0;
        r_rresp  <= w_chk_resp;
        r_rlast  <= (w_chk_beat == w_chk_len);
      end else begin
        r_state  <= S_READ;
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ARVALID) begin
            r_addr  <= bus.ARADDR;
            r_len   <= bus.ARLEN;
            r_beat  <= 8'd0;
            r_cnt   <= CW'(LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: r_cnt <= r_cnt - CW'(1);
        S_READ: r_state <= S_CAPT;
        S_CAPT: begin
          r_rdata  <= bus.mem_rdata;
          r_rresp  <= 2'b00;
          r_rvalid <= 1'b1;
          r_rlast  <= w_last;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (bus.RREADY) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_addr  <= r_addr + 32'd8;
              r_beat  <= r_beat + 8'd1;
              r_cnt   <= CW'(LAT);
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ARREADY  = (r_state == S_IDLE) && ARESETn;
  assign bus.RVALID   = r_rvalid;
  assign bus.RDATA    = r_rdata;
  assign bus.RRESP    = r_rresp;
  assign bus.RLAST    = r_rlast;
  assign bus.mem_en   = (r_state == S_READ);
  assign bus.mem_addr = (r_state == S_READ) ? r_addr : 32'd0;
  assign bus.ARPROT_q = r_prot;

endmodule

// File: tb/tb_axi_rd_mem_slave.sv
// Directed bench for axi_rd_mem_slave: LAT=2 instance for most scenarios,
// LAT=0 instance for the zero-wait latency case.
// SRAM is a behavioural one-cycle read model driven from a fixed data pattern.
module tb_axi_rd_mem_slave;
  logic ACLK;
  logic ARESETn;
  int   checks = 0;
  int   errors = 0;
  int   bad_addr = 0;
  logic [31:0] mem_q[$];

  axi_rd_mem_slave_if ia();
  axi_rd_mem_slave_if ib();

  axi_rd_mem_slave #(.LAT(2)) dut_a (.ACLK(ACLK), .ARESETn(ARESETn), .bus(ia));
  axi_rd_mem_slave #(.LAT(0)) dut_b (.ACLK(ACLK), .ARESETn(ARESETn), .bus(ib));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [63:0] data_of(input logic [31:0] a);
    if (a == 32'h8000_0010) return 64'hDEAD_BEEF_0123_4567;
    return {a ^ 32'hA5A5_0000, a};
  endfunction

  // SRAM models: data valid the cycle after mem_en.
  always @(posedge ACLK) if (ia.mem_en) ia.mem_rdata <= data_of(ia.mem_addr);
  always @(posedge ACLK) if (ib.mem_en) ib.mem_rdata <= data_of(ib.mem_addr);

  // Log SRAM accesses of instance A and watch the idle address.
  always @(negedge ACLK) begin
    if (ia.mem_en === 1'b1) mem_q.push_back(ia.mem_addr);
    else if (ia.mem_addr !== 32'd0) bad_addr++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_a(input logic [31:0] a, input logic [7:0] l, input logic [2:0] p);
    int n = 0;
    ia.ARADDR = a; ia.ARLEN = l; ia.ARPROT = p; ia.ARVALID = 1'b1;
    while (ia.ARREADY !== 1'b1 && n < 50) begin step(); n++; end
    chk("ar accept", {63'd0, ia.ARREADY}, 64'd1);
    step();
    ia.ARVALID = 1'b0;
  endtask

  task automatic beat_a(input string tag, input logic [63:0] ed, input logic [1:0] er,
                        input logic el, input bit hold);
    int n = 0;
    ia.RREADY = 1'b0;
    while (ia.RVALID !== 1'b1 && n < 60) begin step(); n++; end
    chk({tag, " rvalid"}, {63'd0, ia.RVALID}, 64'd1);
    chk({tag, " rdata"}, ia.RDATA, ed);
    chk({tag, " rresp"}, {62'd0, ia.RRESP}, {62'd0, er});
    chk({tag, " rlast"}, {63'd0, ia.RLAST}, {63'd0, el});
    if (hold) begin
      step();
      chk({tag, " hold rvalid"}, {63'd0, ia.RVALID}, 64'd1);
      chk({tag, " hold rdata"}, ia.RDATA, ed);
    end
    ia.RREADY = 1'b1;
    step();
    ia.RREADY = 1'b0;
    chk({tag, " rvalid drop"}, {63'd0, ia.RVALID}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0;
    ia.ARVALID = 1'b0; ia.ARADDR = 32'd0; ia.ARPROT = 3'd0; ia.ARLEN = 8'd0; ia.RREADY = 1'b0;
    ib.ARVALID = 1'b0; ib.ARADDR = 32'd0; ib.ARPROT = 3'd0; ib.ARLEN = 8'd0; ib.RREADY = 1'b0;
    ia.mem_rdata = 64'd0; ib.mem_rdata = 64'd0;

    // Reset state
    step(); step();
    chk("rst arready", {63'd0, ia.ARREADY}, 64'd0);
    chk("rst rvalid", {63'd0, ia.RVALID}, 64'd0);
    chk("rst rdata", ia.RDATA, 64'd0);
    chk("rst rresp", {62'd0, ia.RRESP}, 64'd0);
    chk("rst rlast", {63'd0, ia.RLAST}, 64'd0);
    chk("rst mem_en", {63'd0, ia.mem_en}, 64'd0);
    chk("rst mem_addr", {32'd0, ia.mem_addr}, 64'd0);
    ARESETn = 1'b1;
    #1;
    chk("post rst arready", {63'd0, ia.ARREADY}, 64'd1);

    // Single beat, LAT=2, RREADY held high
    mem_q.delete();
    ia.RREADY = 1'b1;
    start_a(32'h8000_0010, 8'd0, 3'b101);          // edge 0
    chk("t1 arready busy", {63'd0, ia.ARREADY}, 64'd0);
    chk("t1 prot", {61'd0, ia.ARPROT_q}, 64'd5);
    step();                                         // edge 1
    chk("t1 no mem_en e1", {63'd0, ia.mem_en}, 64'd0);
    step();                                         // edge 2
    chk("t1 mem_en", {63'd0, ia.mem_en}, 64'd1);
    chk("t1 mem_addr", {32'd0, ia.mem_addr}, 64'h8000_0010);
    step();                                         // edge 3
    chk("t1 mem_en off", {63'd0, ia.mem_en}, 64'd0);
    chk("t1 rvalid early", {63'd0, ia.RVALID}, 64'd0);
    step();                                         // edge 4
    chk("t1 rvalid", {63'd0, ia.RVALID}, 64'd1);
    chk("t1 rdata", ia.RDATA, 64'hDEAD_BEEF_0123_4567);
    chk("t1 rresp", {62'd0, ia.RRESP}, 64'd0);
    chk("t1 rlast", {63'd0, ia.RLAST}, 64'd1);
    step();                                         // edge 5: handshake
    chk("t1 rvalid drop", {63'd0, ia.RVALID}, 64'd0);
    chk("t1 arready back", {63'd0, ia.ARREADY}, 64'd1);
    chk("t1 mem count", mem_q.size(), 64'd1);
    ia.RREADY = 1'b0;

    // Burst of 4 with RREADY toggling
    mem_q.delete();
    start_a(32'h8000_0000, 8'd3, 3'b000);
    beat_a("t2 b0", 64'h25A5_0000_8000_0000, 2'b00, 1'b0, 1'b1);
    beat_a("t2 b1", 64'h25A5_0008_8000_0008, 2'b00, 1'b0, 1'b1);
    beat_a("t2 b2", 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, 1'b1);
    beat_a("t2 b3", 64'h25A5_0018_8000_0018, 2'b00, 1'b1, 1'b1);
    chk("t2 mem count", mem_q.size(), 64'd4);
    if (mem_q.size() == 4) begin
      chk("t2 addr0", {32'd0, mem_q[0]}, 64'h8000_0000);
      chk("t2 addr1", {32'd0, mem_q[1]}, 64'h8000_0008);
      chk("t2 addr2", {32'd0, mem_q[2]}, 64'h8000_0010);
      chk("t2 addr3", {32'd0, mem_q[3]}, 64'h8000_0018);
    end

    // Misaligned burst: SLVERR on both beats, no SRAM access
    mem_q.delete();
    start_a(32'h8000_0004, 8'd1, 3'b000);
    beat_a("t3 b0", 64'd0, 2'b10, 1'b0, 1'b0);
    beat_a("t3 b1", 64'd0, 2'b10, 1'b1, 1'b0);
    chk("t3 mem count", mem_q.size(), 64'd0);

    // Burst crossing the top of the window
    mem_q.delete();
    start_a(32'h87FF_FFF8, 8'd1, 3'b000);
    beat_a("t4 b0", 64'h225A_FFF8_87FF_FFF8, 2'b00, 1'b0, 1'b0);
    beat_a("t4 b1", 64'd0, 2'b11, 1'b1, 1'b0);
    chk("t4 mem count", mem_q.size(), 64'd1);
    if (mem_q.size() == 1) chk("t4 addr0", {32'd0, mem_q[0]}, 64'h87FF_FFF8);

    // Below the window: DECERR
    start_a(32'h7FFF_FFF8, 8'd0, 3'b000);
    beat_a("t4b", 64'd0, 2'b11, 1'b1, 1'b0);

    // LAT=0 instance
    ib.ARADDR = 32'h8000_0008; ib.ARLEN = 8'd0; ib.RREADY = 1'b1; ib.ARVALID = 1'b1;
    chk("t5 arready", {63'd0, ib.ARREADY}, 64'd1);
    step();                                         // edge 0
    ib.ARVALID = 1'b0;
    chk("t5 mem_en", {63'd0, ib.mem_en}, 64'd1);
    chk("t5 mem_addr", {32'd0, ib.mem_addr}, 64'h8000_0008);
    step();                                         // edge 1
    chk("t5 rvalid early", {63'd0, ib.RVALID}, 64'd0);
    step();                                         // edge 2
    chk("t5 rvalid", {63'd0, ib.RVALID}, 64'd1);
    chk("t5 rdata", ib.RDATA, 64'h25A5_0008_8000_0008);
    chk("t5 rlast", {63'd0, ib.RLAST}, 64'd1);
    step();
    chk("t5 done", {63'd0, ib.RVALID}, 64'd0);
    ib.RREADY = 1'b0;

    // Reset during RESP of beat 1 of a 4-beat burst
    start_a(32'h8000_0000, 8'd3, 3'b000);
    beat_a("t6 b0", 64'h25A5_0000_8000_0000, 2'b00, 1'b0, 1'b0);
    begin
      int n = 0;
      while (ia.RVALID !== 1'b1 && n < 60) begin step(); n++; end
    end
    chk("t6 b1 rvalid", {63'd0, ia.RVALID}, 64'd1);
    ARESETn = 1'b0;
    step();
    mem_q.delete();
    chk("t6 rst rvalid", {63'd0, ia.RVALID}, 64'd0);
    chk("t6 rst rdata", ia.RDATA, 64'd0);
    chk("t6 rst arready", {63'd0, ia.ARREADY}, 64'd0);
    ARESETn = 1'b1;
    #1;
    chk("t6 arready rise", {63'd0, ia.ARREADY}, 64'd1);
    repeat (6) step();
    chk("t6 no mem_en", mem_q.size(), 64'd0);
    chk("t6 idle rvalid", {63'd0, ia.RVALID}, 64'd0);
    start_a(32'h8000_0018, 8'd0, 3'b000);
    beat_a("t6 new", 64'h25A5_0018_8000_0018, 2'b00, 1'b1, 1'b0);

    chk("idle mem_addr zero", bad_addr, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
